int_bit_scan_64: RTL

//  Inverse of the set/clear/test bit-manip unit: takes a 64-bit word and emits, one
//  per beat, the index of each set bit (or clear bit), LSB first. Used by the

---
 rtl/int_bit_scan_64.sv | 134 +++++++++++++
 1 files changed

// File: rtl/int_bit_scan_64.sv
// Streams the index of each set (mode=0) or clear (mode=1) bit of a word, LSB first.
// Optional BIT_SCAN_POPCNT_EN adds out_popcnt, the qualifying-bit count latched at acceptance.
module int_bit_scan_64 #(
  parameter int WIDTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] opa_bit_scan,
  input  logic             mode,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             out_empty,
  output logic             busy
`ifdef BIT_SCAN_POPCNT_EN
  ,
  output logic [IDX_W:0]   out_popcnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    EMPTY = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] residue, residue_next;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] lowest;
  logic [IDX_W-1:0] low_idx;
  logic             one_left;

  assign load_word = mode ? ~opa_bit_scan : opa_bit_scan;

  // Two's-complement trick isolates the lowest set bit; one_left detects a single set bit.
  assign lowest   = residue & (~residue + WIDTH'(1));
  assign one_left = (residue != '0) && ((residue & (residue - WIDTH'(1))) == '0);

  always_comb begin
    low_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (lowest[i]) low_idx = low_idx | IDX_W'(i);
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_index = '0;
    out_last  = 1'b0;
    out_empty = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  in_ready = 1'b1;
      SCAN: begin
        out_valid = 1'b1;
        out_index = low_idx;
        out_last  = one_left;
      end
      EMPTY: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_empty = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next   = state;
    residue_next = residue;
    if (flush) begin
      state_next   = IDLE;
      residue_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            residue_next = load_word;
            state_next   = (load_word == '0) ? EMPTY : SCAN;
          end
        end
        SCAN: begin
          if (out_ready) begin
            residue_next = residue & ~lowest;
            if (one_left) state_next = IDLE;
          end
        end
        EMPTY: begin
          if (out_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      residue <= '0;
    end else begin
      state   <= state_next;
      residue <= residue_next;
    end
  end

`ifdef BIT_SCAN_POPCNT_EN
  logic [IDX_W:0] load_cnt;

  always_comb begin
    load_cnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      load_cnt = load_cnt + (IDX_W+1)'(load_word[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_popcnt <= '0;
    end else if (flush) begin
      out_popcnt <= '0;
    end else if (state == IDLE && in_valid) begin
      out_popcnt <= load_cnt;
    end
  end
`endif

endmodule
